// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter
// Round-robin arbiter for a 16:1 single-bit mux path. A requester is picked
// in IDLE by a circular search that starts at the round-robin pointer. It
// holds the path in BUSY until it signals done or drops its request. Every
// release is followed by exactly one IDLE cycle. After a release the pointer
// moves to the slot just past the released grantee.
//
// Optional feature, selected by the macro MUX16_ARB_TIMEOUT_EN:
//   defined     - a BUSY-cycle counter forces a release once a grant has
//                 lasted TIMEOUT_CYC cycles.
//   not defined - there is no counter, and a grant lasts until done or until
//                 req[sel] drops.
module mux16_rr_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  input  logic [15:0] a,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        gnt_valid,
  output logic        y
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  ptr_q;
  logic [3:0]  sel_q;
  logic [15:0] gnt_q;
  logic        gnt_valid_q;

  logic [3:0]  pick_d;
  logic [3:0]  idx_s;
  logic        any_req_s;
  logic        release_s;
  logic        timeout_hit_s;

  // A zero timeout would make a grant impossible to hold, so reject it at elaboration
  if (TIMEOUT_CYC < 32'd1) begin : g_bad_timeout
    $error("mux16_rr_arbiter: TIMEOUT_CYC must be at least 1");
  end

`ifdef MUX16_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 32'd1);
  logic [CNT_W-1:0] busy_cnt_q;

  // The current BUSY cycle is the last one allowed once TIMEOUT_CYC-1 cycles have gone by
  always_comb begin
    timeout_hit_s = (busy_cnt_q == CNT_W'(TIMEOUT_CYC - 32'd1));
  end

  // BUSY-cycle counter: it clears when a grant is issued and advances on every BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      busy_cnt_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_q + CNT_W'(1);
    end
  end
`else
  // Without the timeout feature a grant ends only on done or a dropped request
  always_comb begin
    timeout_hit_s = 1'b0;
  end
`endif

  // Circular search from ptr_q. The loop runs from the far end toward ptr_q, so the nearest requester is written last and wins
  always_comb begin
    pick_d    = ptr_q;
    idx_s     = ptr_q;
    any_req_s = |req;
    for (int k = 15; k >= 0; k--) begin
      idx_s = ptr_q + 4'(k);
      if (req[idx_s]) begin
        pick_d = idx_s;
      end else begin
        pick_d = pick_d;
      end
    end
  end

  // Release the path on done, on a dropped grantee request or on timeout. When several happen together this is still one release.
  always_comb begin
    release_s = done | ~req[sel_q] | timeout_hit_s;
  end

  // Arbitration FSM; every output is registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 4'd0;
      sel_q       <= 4'd0;
      gnt_q       <= 16'h0000;
      gnt_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_s) begin
            state_q     <= BUSY;
            sel_q       <= pick_d;
            gnt_q       <= 16'h0001 << pick_d;
            gnt_valid_q <= 1'b1;
          end else begin
            state_q     <= IDLE;
            gnt_q       <= 16'h0000;
            gnt_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          if (release_s) begin
            state_q     <= IDLE;
            gnt_q       <= 16'h0000;
            gnt_valid_q <= 1'b0;
            ptr_q       <= sel_q + 4'd1;
          end else begin
            state_q     <= BUSY;
          end
        end
        default: begin
          state_q     <= IDLE;
          gnt_q       <= 16'h0000;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;

  // Mux output. It is forced low whenever no grant is active, and that includes reset.
  always_comb begin
    y = a[sel_q] & gnt_valid_q;
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter. Directed scenarios come first,
// then a randomized phase. A behavioural arbitration model sets the expected
// values for every output.
module tb_mux16_rr_arbiter;

`ifdef MUX16_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [15:0] a;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        gnt_valid;
  logic        y;

  int checks;
  int failures;

  // model state
  bit m_busy;
  int m_ptr;
  int m_sel;
  int m_cnt;

  mux16_rr_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .a         (a),
    .sel       (sel),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .y         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_ptr  = 0;
    m_sel  = 0;
    m_cnt  = 0;
  endtask

  // One clock edge of the arbitration rules, applied to the inputs seen at that edge
  task automatic model_edge(input logic [15:0] r, input logic d);
    if (!m_busy) begin
      if (r != 16'h0000) begin
        for (int k = 0; k < 16; k++) begin
          if (r[(m_ptr + k) % 16]) begin
            m_sel = (m_ptr + k) % 16;
            break;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      m_cnt++;
`ifdef MUX16_ARB_TIMEOUT_EN
      if (d || !r[m_sel] || m_cnt >= TO) begin
`else
      if (d || !r[m_sel]) begin
`endif
        m_busy = 1'b0;
        m_ptr  = (m_sel + 1) % 16;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] eg;
    logic [15:0] av;
    eg = m_busy ? (16'h0001 << m_sel) : 16'h0000;
    av = a;
    chk({tag, ".sel"}, {12'h000, sel}, 16'(m_sel));
    chk({tag, ".gnt_valid"}, {15'h0000, gnt_valid}, {15'h0000, m_busy});
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".y"}, {15'h0000, y}, {15'h0000, (m_busy ? av[m_sel] : 1'b0)});
  endtask

  task automatic step(input string tag, input logic [15:0] r, input logic d, input logic [15:0] av);
    req  = r;
    done = d;
    a    = av;
    @(posedge clk);
    model_edge(r, d);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("reset_async");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    req  = 16'h0000;
    done = 1'b0;
    a    = 16'hFFFF;
    model_reset();
    #2;
    check_all("reset_state");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // idle with no requests, done ignored in IDLE
    step("idle_hold", 16'h0000, 1'b1, 16'hFFFF);
    step("idle_hold2", 16'h0000, 1'b0, 16'hFFFF);

    // first grant after reset, index 3, y from a[3]
    step("req031", 16'h0008, 1'b0, 16'b1000_1111_1111_1001);
    chk("req031.sel3", {12'h000, sel}, 16'd3);
    chk("req031.y1", {15'h0000, y}, 16'd1);
    step("req031_rel", 16'h0008, 1'b1, 16'b1000_1111_1111_1001);

    // all requests held, done once per grant: strictly ascending cyclic order
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step("rr_grant", 16'hFFFF, 1'b0, 16'(i * 16'h1357));
      chk("rr_seq", {12'h000, sel}, 16'(i % 16));
      step("rr_gap", 16'hFFFF, 1'b1, 16'hA5A5);
      chk("rr_gap_valid", {15'h0000, gnt_valid}, 16'd0);
    end

    // grant 15, release, then 8001 must pick 0 (pointer wrapped)
    do_reset();
    step("wrap_g15", 16'h8000, 1'b0, 16'h8000);
    step("wrap_rel", 16'h8000, 1'b1, 16'h8000);
    step("wrap_g0", 16'h8001, 1'b0, 16'h0001);
    chk("wrap_sel0", {12'h000, sel}, 16'd0);
    step("wrap_rel0", 16'h0000, 1'b0, 16'h0001);

    // grant 12 with a[12]=0, other request appears in BUSY
    step("g12", 16'h1000, 1'b0, 16'hEFFF);
    step("g12_req2", 16'h1004, 1'b0, 16'hEFFF);
    chk("g12_stable", {12'h000, sel}, 16'd12);
    chk("g12_y0", {15'h0000, y}, 16'd0);
    step("g12_rel", 16'h1004, 1'b1, 16'hEFFF);
    step("g12_next", 16'h1004, 1'b0, 16'hFFFF);
    step("g12_drop", 16'h0000, 1'b1, 16'hFFFF);

    // reset in BUSY acts immediately
    do_reset();
    step("g5", 16'h0020, 1'b0, 16'hFFFF);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_gv", {15'h0000, gnt_valid}, 16'd0);
    chk("rst_gnt", gnt, 16'h0000);
    chk("rst_sel", {12'h000, sel}, 16'd0);
    chk("rst_y", {15'h0000, y}, 16'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    step("g5_again", 16'h0020, 1'b0, 16'hFFFF);
    chk("g5_sel", {12'h000, sel}, 16'd5);
    step("g5_rel", 16'h0000, 1'b0, 16'hFFFF);

    // single persistent requester: regranted after one idle cycle
    for (int i = 0; i < 12; i++) begin
      step("persist", 16'h0080, 1'b0, 16'h0080);
    end
`ifdef MUX16_ARB_TIMEOUT_EN
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step("timeout", 16'h0080, 1'b0, 16'h0080);
    end
`endif

    // randomized phase
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [15:0] r;
      logic        d;
      r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      d = ($urandom_range(0, 3) == 0);
      step("rand", r, d, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux16_rr_arbiter.md
MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 16, meaning the maximum number of BUSY cycles per grant when the timeout is compiled in.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  16  request vector; bit i high means requester i wants the 16:1 mux path.
REQ-006 done  input  1  the current grantee releases the path; sampled only in BUSY.
REQ-007 a  input  16  mux data inputs, one bit per requester.
REQ-008 sel  output  4  registered select code that drives the 16:1 mux select.
REQ-009 gnt  output  16  registered one-hot grant, equal to (1 << sel) while gnt_valid is high, otherwise 0.
REQ-010 gnt_valid  output  1  registered, high in BUSY.
REQ-011 y  output  1  combinational, equal to a[sel] & gnt_valid.

Function
REQ-012 FSM states SHALL be IDLE and BUSY; there SHALL be a 4-bit round-robin pointer ptr.
REQ-013 IDLE with req == 0: the block SHALL stay in IDLE, and sel and ptr SHALL hold.
REQ-014 IDLE with req != 0: on the next edge the block SHALL enter BUSY.
  - sel = first index i in the order ptr, ptr+1, ... ptr+15 (mod 16) with req[i] = 1.
  - gnt_valid = 1.
REQ-015 Grant latency SHALL be exactly 1 cycle from the IDLE cycle in which the request is sampled to gnt_valid high.
REQ-016 BUSY SHALL persist while req[sel] = 1 and done = 0; sel and gnt SHALL be stable throughout.
REQ-017 BUSY with done = 1 or req[sel] = 0: on the next edge the block SHALL go to IDLE.
  - gnt_valid = 0 and gnt = 0.
  - ptr = sel + 1 mod 16, so index 15 wraps to 0.
  - sel holds its last value.
REQ-018 Between consecutive grants there SHALL be exactly one IDLE cycle with gnt_valid = 0, even if other requests are pending.
REQ-019 Requests from non-granted requesters that assert or deassert in BUSY SHALL NOT affect the current grant.
REQ-020 If done and a drop of req[sel] occur in the same cycle, the block SHALL perform a single release.
REQ-021 done asserted in IDLE SHALL be ignored.
REQ-022 A single persistent requester SHALL be re-granted after one IDLE cycle; ptr wrap-around still selects it.
REQ-023 With all 16 requests held and done pulsed once per grant, grants SHALL visit indices in strictly ascending cyclic order, so no requester starves.

Reset
REQ-024 While rst = 1, independent of clk, the block SHALL force: state = IDLE, ptr = 0, sel = 0, gnt = 0, gnt_valid = 0.
REQ-025 A reset asserted mid-grant SHALL drop gnt_valid immediately, without waiting for a clock edge.
REQ-026 The first arbitration after reset deassertion SHALL search from index 0.
REQ-027 When gnt_valid = 0 (including during reset), y SHALL be 0.

Configuration
REQ-028 Macro MUX16_ARB_TIMEOUT_EN defined: a BUSY-cycle counter SHALL clear on BUSY entry and count each BUSY cycle.
REQ-029 When the count reaches TIMEOUT_CYC, the block SHALL force the REQ-017 release on the next edge, regardless of done or req[sel].
REQ-030 Macro MUX16_ARB_TIMEOUT_EN not defined: there SHALL be no counter and no timeout, and a grant SHALL last until done or req[sel] drops.

Verification
REQ-031 Reset release, then req = 16'h0008 -> one cycle later gnt_valid = 1, sel = 3, gnt = 16'h0008; with a = 16'b1000_1111_1111_1001, y = 1.
REQ-032 req = 16'hFFFF held, done pulsed once per grant -> sel sequence 0,1,2,...,15,0, with one gnt_valid = 0 cycle between grants.
REQ-033 Grant to sel = 15, then done -> ptr = 0; next req = 16'h8001 -> sel = 0, not 15.
REQ-034 Grant to sel = 12 with a[12] = 0 -> y = 0; raise req[2] during BUSY -> sel stays 12 until done.
REQ-035 rst asserted in BUSY with sel = 5 -> gnt_valid, gnt and sel go to 0 without a clock edge; after release, req = 16'h0020 -> sel = 5.
REQ-036 MUX16_ARB_TIMEOUT_EN with TIMEOUT_CYC = 4, req[7] held and done = 0 -> release after 4 BUSY cycles, then regrant to sel = 7 after one IDLE cycle.
